// File: rtl/debug_dump_tx.sv
// Debug dump transmitter: streams PC, cycle count, register bank and
// data memory to uart_tx as little-endian bytes on request.
module debug_dump_tx #(
    parameter int BYTE    = 8,
    parameter int DWORD   = 32,
    parameter int ADDR    = 7,
    parameter int RB_ADDR = 5
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_dump_start,
    input  logic [DWORD-1:0]   i_pc,
    input  logic [DWORD-1:0]   i_cycles,
    output logic [RB_ADDR-1:0] o_rb_addr,
    input  logic [DWORD-1:0]   i_rb_data,
    output logic [ADDR-1:0]    o_dm_addr,
    input  logic [DWORD-1:0]   i_dm_data,
    output logic [BYTE-1:0]    o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_done
);

    localparam int NBW = DWORD / BYTE;
    localparam int BIW = (NBW > 1) ? $clog2(NBW) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_SEND,
        ST_WAIT_TX,
        ST_NEXT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SEC_PC,
        SEC_CYC,
        SEC_RB,
        SEC_DM
    } sec_t;

    state_t             r_state;
    state_t             w_next;
    sec_t               r_sec;
    logic [DWORD-1:0]   r_word;
    logic [DWORD-1:0]   r_cyc;
    logic [BIW-1:0]     r_byte;
    logic [RB_ADDR-1:0] r_rb_idx;
    logic [ADDR-1:0]    r_dm_idx;
    logic [BYTE-1:0]    r_tx_hold;
    logic               w_last_byte;
    logic               w_rb_end;
    logic               w_dm_end;

    assign w_last_byte = (r_byte == BIW'(NBW - 1));
    assign w_rb_end    = &r_rb_idx;
    assign w_dm_end    = &r_dm_idx;
    assign o_rb_addr   = r_rb_idx;
    assign o_dm_addr   = r_dm_idx;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        o_tx_start = 1'b0;
        o_done     = 1'b0;
        o_busy     = 1'b1;
        o_tx_data  = r_tx_hold;
        unique case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_dump_start) w_next = ST_LATCH;
            end
            ST_LATCH:   w_next = ST_SEND;
            ST_RD_REQ:  w_next = ST_RD_WAIT;
            ST_RD_WAIT: w_next = ST_SEND;
            ST_SEND: begin
                o_tx_start = 1'b1;
                o_tx_data  = r_word[BYTE-1:0];
                w_next     = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (i_tx_done) w_next = ST_NEXT;
            end
            ST_NEXT: begin
                if (!w_last_byte) begin
                    w_next = ST_SEND;
                end else begin
                    unique case (r_sec)
                        SEC_PC:  w_next = ST_SEND;
                        SEC_CYC: w_next = ST_RD_REQ;
                        SEC_RB:  w_next = ST_RD_REQ;
                        SEC_DM:  w_next = w_dm_end ? ST_DONE : ST_RD_REQ;
                        default: w_next = ST_IDLE;
                    endcase
                end
            end
            ST_DONE: begin
                o_done = 1'b1;
                o_busy = 1'b0;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Section/word/byte bookkeeping; the shift word always holds the
    // unsent bytes of the current word with the next one in the LSBs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sec     <= SEC_PC;
            r_word    <= '0;
            r_cyc     <= '0;
            r_byte    <= '0;
            r_rb_idx  <= '0;
            r_dm_idx  <= '0;
            r_tx_hold <= '0;
        end else begin
            case (r_state)
                ST_LATCH: begin
                    r_word   <= i_pc;
                    r_cyc    <= i_cycles;
                    r_sec    <= SEC_PC;
                    r_byte   <= '0;
                    r_rb_idx <= '0;
                    r_dm_idx <= '0;
                end
                ST_RD_WAIT: begin
                    r_word <= (r_sec == SEC_RB) ? i_rb_data : i_dm_data;
                end
                ST_SEND: begin
                    r_tx_hold <= r_word[BYTE-1:0];
                end
                ST_NEXT: begin
                    if (!w_last_byte) begin
                        r_byte <= r_byte + BIW'(1);
                        r_word <= r_word >> BYTE;
                    end else begin
                        r_byte <= '0;
                        unique case (r_sec)
                            SEC_PC: begin
                                r_sec  <= SEC_CYC;
                                r_word <= r_cyc;
                            end
                            SEC_CYC: r_sec <= SEC_RB;
                            SEC_RB: begin
                                if (w_rb_end) r_sec <= SEC_DM;
                                else r_rb_idx <= r_rb_idx + RB_ADDR'(1);
                            end
                            SEC_DM: begin
                                if (!w_dm_end) r_dm_idx <= r_dm_idx + ADDR'(1);
                            end
                            default: r_sec <= SEC_PC;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dump_tx.sv
// Randomized bench for debug_dump_tx: a UART TX responder and a frame
// model built from word lists, checked byte by byte.
module tb_debug_dump_tx;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_dump_start;
    logic [31:0] i_pc;
    logic [31:0] i_cycles;
    logic [4:0]  o_rb_addr;
    logic [31:0] i_rb_data;
    logic [6:0]  o_dm_addr;
    logic [31:0] i_dm_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic        o_busy;
    logic        o_done;

    always #5 clk = ~clk;

    debug_dump_tx dut (
        .i_clock     (clk),
        .i_reset     (i_reset),
        .i_dump_start(i_dump_start),
        .i_pc        (i_pc),
        .i_cycles    (i_cycles),
        .o_rb_addr   (o_rb_addr),
        .i_rb_data   (i_rb_data),
        .o_dm_addr   (o_dm_addr),
        .i_dm_data   (i_dm_data),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .i_tx_done   (i_tx_done),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    logic [31:0] rb_mem [0:31];
    logic [31:0] dm_mem [0:127];

    // Read ports with one cycle of latency.
    always @(posedge clk) begin
        i_rb_data <= rb_mem[o_rb_addr];
        i_dm_data <= dm_mem[o_dm_addr];
    end

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_log[$];
    int rx_cnt;
    int done_cnt;
    int dmin;
    int dmax;
    int cnt;
    bit pending;
    bit stray_en;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void build_frame(input logic [31:0] pc,
                                        input logic [31:0] cyc);
        logic [31:0] words[$];
        words.push_back(pc);
        words.push_back(cyc);
        for (int k = 0; k < 32; k++) words.push_back(rb_mem[k]);
        for (int k = 0; k < 128; k++) words.push_back(dm_mem[k]);
        exp_q.delete();
        foreach (words[w])
            for (int b = 0; b < 4; b++)
                exp_q.push_back(words[w][8*b +: 8]);
    endfunction

    // One cycle: step to the falling edge, then act as uart_tx and check.
    task automatic tick();
        @(negedge clk);
        i_tx_done = 1'b0;
        if (!i_reset) begin
            pending = 1'b0;
        end else begin
            if (o_tx_start) begin
                chk("busy_at_start", o_busy, 1);
                chk("start_while_pending", pending, 0);
                chk("byte_in_frame", rx_cnt < exp_q.size(), 1);
                if (rx_cnt < exp_q.size())
                    chk($sformatf("byte%0d", rx_cnt), o_tx_data, exp_q[rx_cnt]);
                rx_log.push_back(o_tx_data);
                rx_cnt++;
                pending = 1'b1;
                cnt = $urandom_range(dmax, dmin);
                if (stray_en && $urandom_range(0, 2) == 0) i_tx_done = 1'b1;
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    i_tx_done = 1'b1;
                    pending = 1'b0;
                end
            end else if (stray_en && $urandom_range(0, 5) == 0) begin
                i_tx_done = 1'b1;
            end
            if (o_done) begin
                done_cnt++;
                chk("done_busy_low", o_busy, 0);
                chk("done_after_all_bytes", rx_cnt, exp_q.size());
            end
        end
    endtask

    task automatic run_dump(input logic [31:0] pc, input logic [31:0] cyc,
                            input int req_at, input int rst_at,
                            input bit scramble);
        int budget;
        bit aborted;
        aborted = 1'b0;
        i_pc = pc;
        i_cycles = cyc;
        build_frame(pc, cyc);
        rx_cnt = 0;
        done_cnt = 0;
        rx_log.delete();
        i_dump_start = 1'b1;
        tick();
        i_dump_start = 1'b0;
        chk("busy_after_req", o_busy, 1);
        repeat (3) tick();
        budget = exp_q.size() * (dmax + 6) + 200;
        for (int n = 0; n < budget && done_cnt == 0 && !aborted; n++) begin
            tick();
            if (scramble) begin
                i_pc = $urandom;
                i_cycles = $urandom;
            end
            i_dump_start = (req_at >= 0 && rx_cnt == req_at);
            if (rst_at >= 0 && rx_cnt >= rst_at) begin
                i_reset = 1'b0;
                aborted = 1'b1;
            end
        end
        i_dump_start = 1'b0;
        if (aborted) begin
            tick();
            chk("rst_tx_start", o_tx_start, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_done, 0);
            chk("no_done_before_rst", done_cnt, 0);
            tick();
            i_reset = 1'b1;
            repeat (2) tick();
        end else begin
            chk("done_in_budget", done_cnt, 1);
            repeat (3) tick();
            chk("done_single", done_cnt, 1);
            chk("byte_count", rx_cnt, exp_q.size());
            chk("busy_after_done", o_busy, 0);
        end
    endtask

    logic [7:0] lit_head [0:7];
    logic [7:0] lit_tail [0:3];
    logic [31:0] npc;

    initial begin
        lit_head = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h10, 8'h00, 8'h00, 8'h00};
        lit_tail = '{8'h7F, 8'h00, 8'h00, 8'hA0};
        i_reset = 1'b0;
        i_dump_start = 1'b0;
        i_pc = '0;
        i_cycles = '0;
        i_tx_done = 1'b0;
        rx_cnt = 0;
        done_cnt = 0;
        pending = 1'b0;
        stray_en = 1'b0;
        dmin = 10;
        dmax = 10;
        for (int k = 0; k < 32; k++) rb_mem[k] = k;
        for (int k = 0; k < 128; k++) dm_mem[k] = 32'hA000_0000 + k;
        exp_q.delete();

        repeat (3) tick();
        chk("rst_o_rb_addr", o_rb_addr, 0);
        chk("rst_o_dm_addr", o_dm_addr, 0);
        chk("rst_o_tx_data", o_tx_data, 0);
        chk("rst_o_tx_start", o_tx_start, 0);
        chk("rst_o_busy", o_busy, 0);
        chk("rst_o_done", o_done, 0);
        i_reset = 1'b1;
        repeat (6) tick();
        chk("idle_no_bytes", rx_cnt, 0);
        chk("idle_busy", o_busy, 0);

        // Clean dump with known data; pin the model with literal bytes.
        run_dump(32'h1234_5678, 32'h0000_0010, -1, -1, 1'b0);
        chk("frame_size", rx_log.size(), 648);
        for (int i = 0; i < 8; i++)
            chk($sformatf("lit_head%0d", i), rx_log[i], lit_head[i]);
        chk("lit_byte8", rx_log[8], 8'h00);
        chk("lit_byte12", rx_log[12], 8'h01);
        for (int i = 0; i < 4; i++)
            chk($sformatf("lit_tail%0d", i), rx_log[644+i], lit_tail[i]);

        // Request mid-dump, stray done pulses, live inputs changing.
        stray_en = 1'b1;
        run_dump(32'hCAFE_0001, 32'h0000_BEEF, 50, -1, 1'b1);

        // Reset at byte 300, then a fresh dump from the PC.
        dmin = 1;
        dmax = 3;
        run_dump(32'h0BAD_F00D, 32'h1111_2222, -1, 300, 1'b1);
        npc = $urandom;
        run_dump(npc, 32'h0000_0042, -1, -1, 1'b1);
        chk("restart_pc_b0", rx_log[0], npc[7:0]);
        chk("restart_pc_b3", rx_log[3], npc[31:24]);

        // Randomized contents and handshake delays.
        dmax = 4;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 32; k++) rb_mem[k] = $urandom;
            for (int k = 0; k < 128; k++) dm_mem[k] = $urandom;
            run_dump($urandom, $urandom, (r == 1) ? int'($urandom_range(0, 647)) : -1,
                     -1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
